// File: rtl/video_ega_blit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_ega_blit_pkg
// Purpose  : Shared video definitions for the EGA latch blitter: VGA/EGA
//            register port numbers, the A0000 memory segment prefix, the
//            blitter state enumeration and bus address helpers.
// Revision : 1.0 - initial release
// ============================================================================
package video_ega_blit_pkg;

  // EGA/VGA register ports (12-bit IO port space)
  localparam logic [11:0] c_PORT_SEQ_IDX = 12'h3C4;
  localparam logic [11:0] c_PORT_SEQ_DAT = 12'h3C5;
  localparam logic [11:0] c_PORT_GC_IDX  = 12'h3CE;
  localparam logic [11:0] c_PORT_GC_DAT  = 12'h3CF;

  // Upper 6 bits of a 20-bit memory address: 5'b10100 then a 0 -> A0000 segment
  localparam logic [5:0]  c_MEM_PREFIX   = 6'b101000;

  // IO step indices: 0..3 program write mode 1 / all planes, 4..5 restore mode 0
  localparam logic [2:0]  c_STEP_CFG_LAST  = 3'd3;
  localparam logic [2:0]  c_STEP_RST_FIRST = 3'd4;
  localparam logic [2:0]  c_STEP_RST_LAST  = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CFG     = 4'd1,
    S_RSETUP  = 4'd2,
    S_RSTROBE = 4'd3,
    S_RWAIT   = 4'd4,
    S_WSTROBE = 4'd5,
    S_ADV     = 4'd6,
    S_RESTORE = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  function automatic logic [19:0] memAddr(input logic [13:0] offset);
    return {c_MEM_PREFIX, offset};
  endfunction

  function automatic logic [19:0] ioAddr(input logic [11:0] port);
    return {8'h00, port};
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_ega_blit_iorom.sv
`default_nettype none
// ============================================================================
// Module   : video_ega_blit_iorom
// Purpose  : Combinational table of the IO writes issued around a blit.
//            Steps 0..3 select write mode 1 and enable all planes; steps
//            4..5 return the graphics controller to write mode 0.
// Ports    : iStep  - step index 0..5
//            oPort  - 12-bit IO port for this step
//            oData  - byte written to that port
// Revision : 1.0 - initial release
// ============================================================================
module video_ega_blit_iorom
  import video_ega_blit_pkg::*;
(
  input  logic [2:0]  iStep,
  output logic [11:0] oPort,
  output logic [7:0]  oData
);

  always_comb begin
    oPort = 12'h000;
    oData = 8'h00;
    unique case (iStep)
      3'd0: begin oPort = c_PORT_GC_IDX;  oData = 8'h05; end  // GC mode register
      3'd1: begin oPort = c_PORT_GC_DAT;  oData = 8'h01; end  // write mode 1
      3'd2: begin oPort = c_PORT_SEQ_IDX; oData = 8'h02; end  // sequencer map mask
      3'd3: begin oPort = c_PORT_SEQ_DAT; oData = 8'h0F; end  // all four planes
      3'd4: begin oPort = c_PORT_GC_IDX;  oData = 8'h05; end
      3'd5: begin oPort = c_PORT_GC_DAT;  oData = 8'h00; end  // back to write mode 0
      default: begin oPort = 12'h000; oData = 8'h00; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/video_ega_blit.sv
`default_nettype none
// ============================================================================
// Module   : video_ega_blit
// Purpose  : EGA latch-copy blitter. Switches the card to write mode 1,
//            then for every byte of a width x height rectangle reads the
//            source (loading all four plane latches) and writes the
//            destination (storing the latches), and finally restores write
//            mode 0. Read data itself is never used.
// Ports    : iClk, iRst          - clock, async active-high reset
//            iStart              - command strobe (accepted only when idle)
//            iSrc/iDst           - 14-bit plane offsets of the rectangles
//            iWidth/iHeight      - bytes per row / rows
//            oAddr, oWrData      - registered bus address / IO write data
//            oWrMem/oRdMem/oWrIo - one-cycle bus strobes
//            iRdData, iSel       - responder read data / read-valid
//            oBusy/oDone/oErr    - status (oErr sticky on read timeout)
// Revision : 1.0 - initial release
// ============================================================================
module video_ega_blit
  import video_ega_blit_pkg::*;
#(
  parameter int STRIDE  = 40,
  parameter int TIMEOUT = 15
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [13:0] iSrc,
  input  logic [13:0] iDst,
  input  logic [5:0]  iWidth,
  input  logic [8:0]  iHeight,
  output logic [19:0] oAddr,
  output logic [7:0]  oWrData,
  output logic        oWrMem,
  output logic        oRdMem,
  output logic        oWrIo,
  input  logic [7:0]  iRdData,
  input  logic        iSel,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  localparam int             c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
  localparam logic [13:0]    c_STRIDE    = 14'(STRIDE);

  state_t              r_state,   w_stateNext;
  logic [2:0]          r_step,    w_stepNext;
  logic [5:0]          r_width,   w_widthNext;
  logic [8:0]          r_height,  w_heightNext;
  logic [5:0]          r_col,     w_colNext;
  logic [8:0]          r_row,     w_rowNext;
  logic [13:0]         r_rowSrc,  w_rowSrcNext;
  logic [13:0]         r_rowDst,  w_rowDstNext;
  logic [c_WAIT_W-1:0] r_waitCnt, w_waitNext;
  logic                r_selSeen, w_selSeenNext;
  logic                r_err,     w_errNext;

  logic [19:0]         r_addr,    w_addrNext;
  logic [7:0]          r_wrData,  w_wrDataNext;
  logic                r_wrMem,   w_wrMemNext;
  logic                r_rdMem,   w_rdMemNext;
  logic                r_wrIo,    w_wrIoNext;
  logic                r_busy,    w_busyNext;
  logic                r_done,    w_doneNext;

  logic [11:0]         w_romPort;
  logic [7:0]          w_romData;
  logic                w_lastCol;
  logic                w_lastRow;
  logic                w_unusedRdData;

  // Only the card's plane latches carry the data; the byte read is discarded.
  assign w_unusedRdData = ^iRdData;

  assign w_lastCol = (r_col == r_width - 6'd1);
  assign w_lastRow = (r_row == r_height - 9'd1);

  // The ROM is indexed by the next step so its entry lands in the output
  // registers on the same edge the FSM enters the IO state.
  video_ega_blit_iorom u_iorom (
    .iStep (w_stepNext),
    .oPort (w_romPort),
    .oData (w_romData)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_step    <= 3'd0;
      r_width   <= 6'd0;
      r_height  <= 9'd0;
      r_col     <= 6'd0;
      r_row     <= 9'd0;
      r_rowSrc  <= 14'd0;
      r_rowDst  <= 14'd0;
      r_waitCnt <= '0;
      r_selSeen <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= 20'd0;
      r_wrData  <= 8'd0;
      r_wrMem   <= 1'b0;
      r_rdMem   <= 1'b0;
      r_wrIo    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_step    <= w_stepNext;
      r_width   <= w_widthNext;
      r_height  <= w_heightNext;
      r_col     <= w_colNext;
      r_row     <= w_rowNext;
      r_rowSrc  <= w_rowSrcNext;
      r_rowDst  <= w_rowDstNext;
      r_waitCnt <= w_waitNext;
      r_selSeen <= w_selSeenNext;
      r_err     <= w_errNext;
      r_addr    <= w_addrNext;
      r_wrData  <= w_wrDataNext;
      r_wrMem   <= w_wrMemNext;
      r_rdMem   <= w_rdMemNext;
      r_wrIo    <= w_wrIoNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_stateNext   = r_state;
    w_stepNext    = r_step;
    w_widthNext   = r_width;
    w_heightNext  = r_height;
    w_colNext     = r_col;
    w_rowNext     = r_row;
    w_rowSrcNext  = r_rowSrc;
    w_rowDstNext  = r_rowDst;
    w_waitNext    = r_waitCnt;
    w_selSeenNext = r_selSeen;
    w_errNext     = r_err;

    unique case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_widthNext  = iWidth;
          w_heightNext = iHeight;
          w_rowSrcNext = iSrc;
          w_rowDstNext = iDst;
          w_colNext    = 6'd0;
          w_rowNext    = 9'd0;
          w_stepNext   = 3'd0;
          w_errNext    = 1'b0;
          w_stateNext  = (iWidth == 6'd0 || iHeight == 9'd0) ? S_DONE : S_CFG;
        end
      end
      S_CFG: begin
        if (r_step == c_STEP_CFG_LAST) w_stateNext = S_RSETUP;
        else                           w_stepNext  = r_step + 3'd1;
      end
      S_RSETUP: w_stateNext = S_RSTROBE;
      S_RSTROBE: begin
        // An early iSel (same cycle as the read strobe) is remembered here.
        w_stateNext   = S_RWAIT;
        w_waitNext    = '0;
        w_selSeenNext = iSel;
      end
      S_RWAIT: begin
        if (iSel || r_selSeen) begin
          w_stateNext   = S_WSTROBE;
          w_selSeenNext = 1'b0;
        end else if (r_waitCnt == c_WAIT_LAST) begin
          w_errNext   = 1'b1;
          w_stepNext  = c_STEP_RST_FIRST;
          w_stateNext = S_RESTORE;
        end else begin
          w_waitNext = r_waitCnt + 1'b1;
        end
      end
      S_WSTROBE: w_stateNext = S_ADV;
      S_ADV: begin
        if (w_lastCol) begin
          w_colNext    = 6'd0;
          w_rowNext    = r_row + 9'd1;
          w_rowSrcNext = r_rowSrc + c_STRIDE;
          w_rowDstNext = r_rowDst + c_STRIDE;
        end else begin
          w_colNext = r_col + 6'd1;
        end
        if (w_lastCol && w_lastRow) begin
          w_stepNext  = c_STEP_RST_FIRST;
          w_stateNext = S_RESTORE;
        end else begin
          w_stateNext = S_RSETUP;
        end
      end
      S_RESTORE: begin
        if (r_step == c_STEP_RST_LAST) w_stateNext = S_DONE;
        else                           w_stepNext  = r_step + 3'd1;
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every bus output is a register
  // that is stable for the whole cycle of the state it belongs to.
  always_comb begin
    w_addrNext   = r_addr;
    w_wrDataNext = r_wrData;
    w_wrMemNext  = 1'b0;
    w_rdMemNext  = 1'b0;
    w_wrIoNext   = 1'b0;
    w_doneNext   = 1'b0;
    w_busyNext   = (w_stateNext != S_IDLE);

    unique case (w_stateNext)
      S_CFG, S_RESTORE: begin
        w_wrIoNext   = 1'b1;
        w_addrNext   = ioAddr(w_romPort);
        w_wrDataNext = w_romData;
      end
      S_RSETUP: w_addrNext = memAddr(w_rowSrcNext + {8'd0, w_colNext});
      S_RSTROBE: begin
        w_addrNext  = memAddr(w_rowSrcNext + {8'd0, w_colNext});
        w_rdMemNext = 1'b1;
      end
      S_WSTROBE: begin
        w_addrNext  = memAddr(w_rowDstNext + {8'd0, w_colNext});
        w_wrMemNext = 1'b1;
      end
      S_DONE:  w_doneNext = 1'b1;
      default: ;
    endcase
  end

  assign oAddr   = r_addr;
  assign oWrData = r_wrData;
  assign oWrMem  = r_wrMem;
  assign oRdMem  = r_rdMem;
  assign oWrIo   = r_wrIo;
  assign oBusy   = r_busy;
  assign oDone   = r_done;
  assign oErr    = r_err;

endmodule
`default_nettype wire
